uart_word_bridge: RTL
=====================

# uart_word_bridge

Host-link bridge between the PC-side UART and the core. It assembles received bytes into `8*BYTES`-bit words and buffers them in an RX FIFO read by the core with a valid/ready handshake. Core words are buffered in a TX FIFO and serialised LSB-byte-first. It can optionally return a per-word acknowledge byte carrying core status (init complete / normal). It supersedes the single-byte status loopback used during program load.

## Interface
- `CLK_PER_HALF_BIT`, 5208, UART half-bit period in clk cycles; passed to `uart_rx`/`uart_tx`.
- `BYTES`, 4, bytes per word; 1..8.
- `DEPTH`, 16, entries per FIFO; power of two, ≥2.
- `ACK_INIT`, 8'h99, acknowledge byte when `init_done`=1.
- `ACK_NORM`, 8'h66, acknowledge byte when `init_done`=0.

Ports:
- `clk` in 1 clock
- `rstn` in 1 reset, synchronous, active-low
- `rxd` in 1 UART serial in
- `txd` out 1 UART serial out
- `rx_word` out 8*BYTES head of RX FIFO (show-ahead)
- `rx_valid` out 1 RX FIFO non-empty
- `rx_ready` in 1 core consumes head when `rx_valid`&`rx_ready`
- `tx_word` in 8*BYTES word to send
- `tx_valid` in 1 core offers `tx_word`
- `tx_ready` out 1 TX FIFO not full
- `init_done` in 1 core status selecting ack byte
- `rx_level` out $clog2(DEPTH)+1 RX FIFO occupancy
- `overflow` out 1 sticky: received word dropped, RX FIFO full
- `frame_err` out 1 sticky: byte with stop-bit error seen
- `clr_err` in 1 clears both sticky flags

## Operation
- RX assembly: byte index `bi` 0..BYTES-1. Each good byte (`uart_rx` ready, ferr=0) is written to lane `bi` (byte 0 = bits 7:0), and `bi` increments.
- On the last byte, the word is pushed and `bi` returns to 0.
- Frame error byte: discarded, `bi` reset to 0 (partial word dropped), `frame_err` set.
- Push when RX FIFO full: word dropped, FIFO unchanged, `overflow` set.
- Push and pop in the same cycle when full: both happen, no overflow.
- Sticky flags: a set in the same cycle as `clr_err` wins (flag stays 1).
- TX FIFO write on `tx_valid`&`tx_ready`. Simultaneous write and read-out are allowed.
- TX FSM states:
  - IDLE: if an ack is pending, go to ACK; else if TX FIFO non-empty, pop into the shift register, set `k`=0, go to SEND.
  - SEND: drive byte `k` to `uart_tx`, assert `tx_start` one cycle, go to GUARD.
  - GUARD: one cycle wait for `tx_busy` to rise, then go to WAIT.
  - WAIT: when `tx_busy`=0, if `k`=BYTES-1 go to IDLE; else increment `k` and go to SEND.
  - ACK: send the latched ack byte via SEND/GUARD/WAIT with a single-byte count, then clear pending and go to IDLE.
- Acks are never inserted inside a word. A pending ack beats a queued word at IDLE.
- The ack value is latched from `init_done` in the cycle the RX word is pushed.
- Pending acks are counted with a saturating counter, width $clog2(DEPTH)+1. At saturation, further acks are lost silently.

## Timing
- Reset values: `rx_valid`=0, `rx_word`=0, `tx_ready`=1, `rx_level`=0, `overflow`=0, `frame_err`=0, `txd`=1, FSM=IDLE, `bi`=0, pending acks=0. Both FIFOs are emptied.
- Reset mid-frame: partial words and in-flight bytes are abandoned. `txd` returns high in the next cycle via `uart_tx` reset.
- RX latency: `rx_valid` rises 1 cycle after the final byte's `uart_rx` ready pulse. `rx_level` updates in the same cycle.
- Pop: on `rx_valid`&`rx_ready` at edge N, the next head (or `rx_valid`=0) appears after edge N.
- `tx_ready` falls in the cycle after the write that fills the FIFO.
- TX: first `tx_start` 2 cycles after the TX FIFO becomes non-empty while in IDLE (IDLE pop, then SEND).
- Gap between bytes of a word: 2 cycles after `tx_busy` falls.

## Configuration
- `UART_BRIDGE_ACK_EN` defined: the ack path described above is built.
- Not defined: no ack logic, the ACK state is absent, and the `init_done` port remains but is ignored. TX carries only core words.

## Structure
- Package `uart_bridge_pkg`:
  - TX FSM state enum (IDLE, SEND, GUARD, WAIT, ACK);
  - `ACK_INIT`/`ACK_NORM` defaults;
  - helper function for level width.
- Sub-module `uart_sync_fifo`, parameters WIDTH and DEPTH, show-ahead, with full/empty/level outputs. It is instantiated twice.
- Existing `uart_rx`/`uart_tx` are reused unchanged.

## Test plan
- BYTES=4: host sends 0x78,0x56,0x34,0x12 → `rx_word`=32'h12345678 and `rx_valid`=1 one cycle after the last byte.
- Bad stop bit on the 2nd byte, then 4 good bytes 0x01..0x04 → `frame_err`=1 and `rx_word`=32'h04030201. `clr_err` then clears the flag.
- DEPTH=4 with `rx_ready`=0: 5 words sent → `rx_level`=4, `overflow`=1. The 5th word is absent when draining.
- Core writes 32'hDEADBEEF → `txd` carries bytes EF,BE,AD,DE in order with no interleaving.
- ACK_EN, `init_done`=1, receive a word while a TX word is mid-send → 0x99 is sent after that word completes and before the next queued word.
- Assert `rstn`=0 during the 3rd byte of a TX word → `txd`=1 and FIFOs empty next cycle. A fresh word afterwards is sent intact.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART word bridge: TX FSM states,
// default acknowledge bytes and the FIFO level width helper.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GUARD,
    WAIT,
    ACK
  } tx_state_e;

  localparam logic [7:0] ACK_INIT_DEFAULT = 8'h99;
  localparam logic [7:0] ACK_NORM_DEFAULT = 8'h66;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver, 8N1. Emits a one-cycle ready pulse with the byte and a
// stop-bit error flag; waits for an idle-high line before re-arming.
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       ready,
  output logic       ferr
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_REARM} rx_state_e;

  rx_state_e     state;
  rx_state_e     next_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          s1;
  logic          s2;
  logic          bit_end;

  assign bit_end = (cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (!rstn) state <= RX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (!s2) next_state = RX_START;
      RX_START: if (cnt == HALF_END) next_state = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bitn == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (bit_end) next_state = RX_REARM;
      RX_REARM: if (s2) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  // Counter restarts on every state change and at each data bit boundary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
      data  <= '0;
      ready <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      ready <= (state == RX_STOP) && bit_end;
      ferr  <= (state == RX_STOP) && bit_end && !s2;
      if (state != next_state || state == RX_IDLE || (state == RX_DATA && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == RX_START) bitn <= '0;
      if (state == RX_DATA && bit_end) begin
        sh   <= {s2, sh[7:1]};
        bitn <= bitn + 1'b1;
      end
      if (state == RX_STOP && bit_end) data <= sh;
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/level status. A write while
// full is accepted only when a read happens in the same cycle.
module uart_sync_fifo
  import uart_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1. A start pulse while idle latches the byte; busy
// stays high from the following cycle until the stop bit has completed.
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txs_state_e;

  txs_state_e    state;
  txs_state_e    next_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          bit_end;

  assign bit_end = (cnt == BIT_END);
  assign busy    = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= TX_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE:  if (start) next_state = TX_START;
      TX_START: if (bit_end) next_state = TX_DATA;
      TX_DATA:  if (bit_end && bitn == 3'd7) next_state = TX_STOP;
      TX_STOP:  if (bit_end) next_state = TX_IDLE;
      default:  next_state = TX_IDLE;
    endcase
  end

  // txd is registered so the line never glitches between bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
      txd  <= 1'b1;
    end else begin
      if (state != next_state || state == TX_IDLE || (state == TX_DATA && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == TX_IDLE && start) begin
        sh   <= data;
        bitn <= '0;
        txd  <= 1'b0;
      end
      if (state == TX_START && bit_end) txd <= sh[0];
      if (state == TX_DATA && bit_end) begin
        sh   <= sh >> 1;
        bitn <= bitn + 1'b1;
        txd  <= (bitn == 3'd7) ? 1'b1 : sh[1];
      end
    end
  end

endmodule

// File: rtl/uart_word_bridge.sv
// Host-link bridge: UART bytes <-> 8*BYTES-bit words through RX/TX FIFOs.
// Define UART_BRIDGE_ACK_EN to build the per-word acknowledge byte path.
module uart_word_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         CLK_PER_HALF_BIT = 5208,
  parameter int         BYTES            = 4,
  parameter int         DEPTH            = 16,
  parameter logic [7:0] ACK_INIT         = ACK_INIT_DEFAULT,
  parameter logic [7:0] ACK_NORM         = ACK_NORM_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic                          txd,
  output logic [8*BYTES-1:0]            rx_word,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [8*BYTES-1:0]            tx_word,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          init_done,
  output logic [level_width(DEPTH)-1:0] rx_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);
  localparam int W   = 8 * BYTES;
  localparam int LW  = level_width(DEPTH);
  localparam int BIW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIW-1:0] LAST = BIW'(BYTES - 1);

  logic [7:0]     rxb_data;
  logic           rxb_ready;
  logic           rxb_ferr;
  logic [BIW-1:0] bi;
  logic [W-1:0]   asm_word;
  logic [W-1:0]   push_word;
  logic [W-1:0]   rx_head;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_accept;

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk(clk), .rstn(rstn), .rxd(rxd),
    .data(rxb_data), .ready(rxb_ready), .ferr(rxb_ferr)
  );

  always_comb begin
    push_word = asm_word;
    push_word[int'(bi) * 8 +: 8] = rxb_data;
  end

  assign rx_push   = rxb_ready & ~rxb_ferr & (bi == LAST);
  assign rx_pop    = rx_ready & ~rx_empty;
  assign rx_accept = rx_push & (~rx_full | rx_pop);

  // A stop-bit error throws away the partially assembled word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bi       <= '0;
      asm_word <= '0;
    end else if (rxb_ready) begin
      if (rxb_ferr || bi == LAST) begin
        bi <= '0;
      end else begin
        bi       <= bi + 1'b1;
        asm_word <= push_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop) overflow <= 1'b1;
      else if (clr_err)                  overflow <= 1'b0;
      if (rxb_ready && rxb_ferr)         frame_err <= 1'b1;
      else if (clr_err)                  frame_err <= 1'b0;
    end
  end

  uart_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .wr_en(rx_push), .wr_data(push_word),
    .rd_en(rx_pop), .rd_data(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign rx_valid = ~rx_empty;
  assign rx_word  = rx_empty ? '0 : rx_head;

  logic [W-1:0]   tx_head;
  logic           tx_full;
  logic           tx_empty;
  logic           tx_pop;
  logic [LW-1:0]  tx_level_unused;
  tx_state_e      state;
  tx_state_e      next_state;
  logic [W-1:0]   shreg;
  logic [BIW-1:0] k;
  logic [BIW-1:0] k_last;
  logic           k_inc;
  logic           tx_start;
  logic           tx_busy;
  logic [7:0]     tx_data;

  assign tx_ready = ~tx_full;

  uart_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .wr_en(tx_valid & tx_ready), .wr_data(tx_word),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level_unused)
  );

`ifdef UART_BRIDGE_ACK_EN
  logic [LW-1:0] pend;
  logic [7:0]    ack_byte;
  logic          ack_inc;
  logic          ack_dec;

  assign ack_dec = (state == ACK);
  assign ack_inc = rx_accept & ((pend != {LW{1'b1}}) | ack_dec);

  // The ack value follows init_done at the moment the word enters the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend     <= '0;
      ack_byte <= ACK_NORM;
    end else begin
      if (rx_accept) ack_byte <= init_done ? ACK_INIT : ACK_NORM;
      case ({ack_inc, ack_dec})
        2'b10:   pend <= pend + 1'b1;
        2'b01:   pend <= pend - 1'b1;
        default: pend <= pend;
      endcase
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ^{init_done, ACK_INIT, ACK_NORM, rx_accept};
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_pop     = 1'b0;
    tx_start   = 1'b0;
    k_inc      = 1'b0;
    case (state)
      IDLE: begin
`ifdef UART_BRIDGE_ACK_EN
        if (pend != '0) next_state = ACK;
        else
`endif
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          next_state = SEND;
        end
      end
`ifdef UART_BRIDGE_ACK_EN
      ACK:   next_state = SEND;
`endif
      SEND: begin
        tx_start   = 1'b1;
        next_state = GUARD;
      end
      GUARD: next_state = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (k == k_last) begin
            next_state = IDLE;
          end else begin
            k_inc      = 1'b1;
            next_state = SEND;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // An ack reuses the word datapath as a one-byte word in lane 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg  <= '0;
      k      <= '0;
      k_last <= '0;
    end else begin
      if (tx_pop) begin
        shreg  <= tx_head;
        k      <= '0;
        k_last <= LAST;
      end
      if (k_inc) k <= k + 1'b1;
`ifdef UART_BRIDGE_ACK_EN
      if (state == ACK) begin
        shreg  <= W'(ack_byte);
        k      <= '0;
        k_last <= '0;
      end
`endif
    end
  end

  assign tx_data = shreg[int'(k) * 8 +: 8];

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk(clk), .rstn(rstn),
    .start(tx_start), .data(tx_data),
    .busy(tx_busy), .txd(txd)
  );

endmodule
